// File: rtl/ponylink_pkg.sv
// Shared PonyLink link-controller definitions: state encoding and sizing helper.
// Also used by status/debug readout logic.
package ponylink_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_RESET   = 3'd1;
    localparam logic [STATE_W-1:0] ST_TRAIN   = 3'd2;
    localparam logic [STATE_W-1:0] ST_STABLE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_UP      = 3'd4;
    localparam logic [STATE_W-1:0] ST_BACKOFF = 3'd5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ponylink_satcnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ponylink_satcnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ponylink_master_linkctl.sv
// Master-side PonyLink bring-up FSM: drives txrx reset, waits for training,
// qualifies stability and retries with exponential backoff.
module ponylink_master_linkctl
    import ponylink_pkg::*;
#(
    parameter int RESET_CYCLES      = 64,
    parameter int TRAIN_TIMEOUT     = 4096,
    parameter int STABLE_CYCLES     = 16,
    parameter int BACKOFF_MAX_SHIFT = 4,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_counters,
    input  logic                 txrx_linkready,
    input  logic                 txrx_linkerror,
    output logic                 txrx_resetn,
    output logic                 link_up,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] retry_count
);

    localparam int BACKOFF_LONGEST = RESET_CYCLES << BACKOFF_MAX_SHIFT;
    localparam int TIMER_SPAN      = max3(TRAIN_TIMEOUT, STABLE_CYCLES, BACKOFF_LONGEST);
    localparam int TW              = (TIMER_SPAN > 1) ? $clog2(TIMER_SPAN) : 1;
    localparam int SW              = (BACKOFF_MAX_SHIFT > 0) ? $clog2(BACKOFF_MAX_SHIFT + 1) : 1;

    logic [TW-1:0] timer, next_timer;
    logic [SW-1:0] streak, next_streak, streak_sat;
    logic [2:0]    next_state;
    logic          timer_zero, go_backoff, err_inc, retry_inc;

    assign timer_zero = (timer == '0);
    assign streak_sat = (int'(streak) >= BACKOFF_MAX_SHIFT) ? SW'(BACKOFF_MAX_SHIFT)
                                                            : streak + SW'(1);

    always_comb begin
        next_state  = state;
        next_timer  = timer;
        next_streak = streak;
        go_backoff  = 1'b0;
        err_inc     = 1'b0;
        retry_inc   = 1'b0;

        case (state)
            ST_IDLE: begin
                next_streak = '0;
                if (enable) begin
                    next_state = ST_RESET;
                    next_timer = TW'(RESET_CYCLES - 1);
                end
            end
            ST_RESET: begin
                if (timer_zero) begin
                    next_state = ST_TRAIN;
                    next_timer = TW'(TRAIN_TIMEOUT - 1);
                end else begin
                    next_timer = timer - TW'(1);
                end
            end
            ST_TRAIN: begin
                // Error wins even when linkready is asserted alongside it.
                if (txrx_linkerror) begin
                    go_backoff = 1'b1;
                    err_inc    = 1'b1;
                end else if (txrx_linkready) begin
                    next_state = ST_STABLE;
                    next_timer = TW'(STABLE_CYCLES - 1);
                end else if (timer_zero) begin
                    go_backoff = 1'b1;
                end else begin
                    next_timer = timer - TW'(1);
                end
            end
            ST_STABLE: begin
                if (txrx_linkerror || !txrx_linkready) begin
                    go_backoff = 1'b1;
                    err_inc    = txrx_linkerror;
                end else if (timer_zero) begin
                    next_state  = ST_UP;
                    next_streak = '0;
                end else begin
                    next_timer = timer - TW'(1);
                end
            end
            ST_UP: begin
                if (txrx_linkerror || !txrx_linkready) begin
                    go_backoff = 1'b1;
                    err_inc    = txrx_linkerror;
                end
            end
            ST_BACKOFF: begin
                // Retries go straight back to training, skipping RESET.
                if (timer_zero) begin
                    next_state = ST_TRAIN;
                    next_timer = TW'(TRAIN_TIMEOUT - 1);
                end else begin
                    next_timer = timer - TW'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_timer = '0;
            end
        endcase

        if (go_backoff) begin
            next_state  = ST_BACKOFF;
            retry_inc   = 1'b1;
            next_streak = streak_sat;
            next_timer  = TW'((RESET_CYCLES << streak_sat) - 1);
        end

        if (!enable) begin
            next_state  = ST_IDLE;
            next_timer  = '0;
            next_streak = '0;
            err_inc     = 1'b0;
            retry_inc   = 1'b0;
        end
    end

    // Outputs are registered from next_state so they change with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            streak      <= '0;
            txrx_resetn <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            state       <= next_state;
            timer       <= next_timer;
            streak      <= next_streak;
            txrx_resetn <= (next_state == ST_TRAIN) || (next_state == ST_STABLE) ||
                           (next_state == ST_UP);
            link_up     <= (next_state == ST_UP);
        end
    end

    ponylink_satcnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clear_counters),
        .count (err_count)
    );

    ponylink_satcnt #(.WIDTH(CNT_WIDTH)) u_retry_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (retry_inc),
        .clr   (clear_counters),
        .count (retry_count)
    );

endmodule
